// File: rtl/debug_trace_buffer.sv
// Debug-bus logic analyzer: circular capture of {pc, inst, alu}, PC-match trigger, oldest-first readout.
// Capture and control take effect on the edge that sees them; rd_data lags DONE by one edge.
// Readout holds rd_valid/rd_data/rd_ts while rd_ready is low. `TRACE_TIMESTAMP_EN adds per-entry 16-bit stamps.
module debug_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_pc,
    input  logic [DATA_W-1:0]         in_inst,
    input  logic [DATA_W-1:0]         in_alu,
    input  logic                      arm,
    input  logic                      stop,
    input  logic [DATA_W-1:0]         trig_pc,
    output logic [1:0]                state,
    output logic                      triggered,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [3*DATA_W-1:0]       rd_data,
    output logic [15:0]               rd_ts
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 3 * DATA_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] POST_C  = CW'(POST_TRIG);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARMED = 2'b01,
        S_POST  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic            triggered_q, triggered_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   post_cnt_q, post_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            rd_valid_q, rd_valid_d;
    logic [EW-1:0]   rd_data_q, rd_data_d;
    logic            wr_en;
    logic            rd_load;

    logic [EW-1:0]   mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        triggered_d = triggered_q;
        count_d     = count_q;
        post_cnt_d  = post_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        wr_en       = 1'b0;
        rd_load     = 1'b0;

        if (arm) begin
            state_d     = S_ARMED;
            triggered_d = 1'b0;
            count_d     = '0;
            post_cnt_d  = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            rd_valid_d  = 1'b0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (in_valid) begin
                        wr_en = 1'b1;
                    end
                    // A trigger seen together with stop takes precedence over stop.
                    if (in_valid && (in_pc == trig_pc)) begin
                        triggered_d = 1'b1;
                        if (POST_TRIG == 0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_POST;
                            post_cnt_d = POST_C;
                        end
                    end else if (stop) begin
                        state_d = S_DONE;
                    end
                end
                S_POST: begin
                    if (in_valid) begin
                        wr_en      = 1'b1;
                        post_cnt_d = post_cnt_q - ONE_C;
                        if (post_cnt_q == ONE_C) begin
                            state_d = S_DONE;
                        end
                    end
                    if (stop) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (!rd_valid_q) begin
                        if (count_q == '0) begin
                            state_d = S_IDLE;
                        end else begin
                            rd_load    = 1'b1;
                            rd_valid_d = 1'b1;
                        end
                    end else if (rd_ready) begin
                        count_d = count_q - ONE_C;
                        if (count_q == ONE_C) begin
                            rd_valid_d = 1'b0;
                            state_d    = S_IDLE;
                        end else begin
                            rd_load = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q != DEPTH_C) begin
                count_d = count_q + ONE_C;
            end
        end

        if (rd_load) begin
            rd_data_d = mem[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + AW'(1);
        end

        // Oldest entry sits count entries behind the write pointer; a full buffer wraps to wr_ptr itself.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            triggered_q <= 1'b0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            triggered_q <= triggered_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {in_pc, in_inst, in_alu};
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] rd_ts_q;
    logic [15:0] mem_ts [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q    <= '0;
            rd_ts_q <= '0;
        end else begin
            ts_q <= ts_q + 16'd1;
            if (rd_load) begin
                rd_ts_q <= mem_ts[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_ts[wr_ptr_q] <= ts_q;
        end
    end

    assign rd_ts = rd_ts_q;
`else
    assign rd_ts = 16'd0;
`endif

    assign state     = state_q;
    assign triggered = triggered_q;
    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer (DEPTH=16, POST_TRIG=8).
module tb_debug_trace_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [31:0] in_alu;
    logic        arm;
    logic        stop;
    logic [31:0] trig_pc;
    logic [1:0]  state;
    logic        triggered;
    logic [4:0]  count;
    logic        rd_valid;
    logic        rd_ready;
    logic [95:0] rd_data;
    logic [15:0] rd_ts;

    int checks = 0;
    int errors = 0;

    debug_trace_buffer #(.DATA_W(32), .DEPTH(16), .POST_TRIG(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_inst  (in_inst),
        .in_alu   (in_alu),
        .arm      (arm),
        .stop     (stop),
        .trig_pc  (trig_pc),
        .state    (state),
        .triggered(triggered),
        .count    (count),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_ts    (rd_ts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] ent(input int k);
        logic [31:0] pc, inst, alu;
        pc   = 32'(4 * k);
        inst = 32'hA000_0000 + 32'(k);
        alu  = 32'hB000_0000 + 32'(k);
        return {pc, inst, alu};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k);
        in_valid = 1'b1;
        in_pc    = 32'(4 * k);
        in_inst  = 32'hA000_0000 + 32'(k);
        in_alu   = 32'hB000_0000 + 32'(k);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic feed_range(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            drive(k);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int first, input int n);
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_vld%0d", tag, i), 128'(rd_valid), 128'(1));
            chk($sformatf("%s_dat%0d", tag, i), 128'(rd_data), 128'(ent(first + i)));
            step();
        end
        rd_ready = 1'b0;
        chk({tag, "_end_vld"}, 128'(rd_valid), 128'(0));
        chk({tag, "_end_state"}, 128'(state), 128'(0));
        chk({tag, "_end_count"}, 128'(count), 128'(0));
    endtask

    logic [15:0] ts0, ts1, ts2;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_pc    = '0;
        in_inst  = '0;
        in_alu   = '0;
        arm      = 1'b0;
        stop     = 1'b0;
        trig_pc  = '0;
        rd_ready = 1'b0;
        #12;
        chk("rst_state", 128'(state), 128'(0));
        chk("rst_trig", 128'(triggered), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_vld", 128'(rd_valid), 128'(0));
        chk("rst_data", 128'(rd_data), 128'(0));
        chk("rst_ts", 128'(rd_ts), 128'(0));
        step();
        rst = 1'b0;
        step();

        // Normal trigger at pc 0x28, buffer wraps, window 0x0C..0x48
        do_arm();
        chk("norm_armed", 128'(state), 128'(1));
        trig_pc = 32'h28;
        feed_range(0, 30);
        chk("norm_state", 128'(state), 128'(3));
        chk("norm_trig", 128'(triggered), 128'(1));
        chk("norm_count", 128'(count), 128'(16));
`ifndef TRACE_TIMESTAMP_EN
        chk("norm_ts_zero", 128'(rd_ts), 128'(0));
`endif
        drain("norm", 3, 16);

        // Trigger on the very first sample
        do_arm();
        trig_pc = 32'h0;
        feed_range(0, 30);
        chk("early_count", 128'(count), 128'(9));
        chk("early_trig", 128'(triggered), 128'(1));
        drain("early", 0, 9);

        // Stop without trigger, then backpressure and re-arm mid-readout
        do_arm();
        trig_pc = 32'hFFFF_FFFF;
        feed_range(0, 4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_state", 128'(state), 128'(3));
        chk("stop_trig", 128'(triggered), 128'(0));
        chk("stop_count", 128'(count), 128'(5));
        chk("stop_vld_lag", 128'(rd_valid), 128'(0));
        step();
        chk("stop_vld", 128'(rd_valid), 128'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_vld%0d", i), 128'(rd_valid), 128'(1));
            chk($sformatf("bp_dat%0d", i), 128'(rd_data), 128'(ent(0)));
        end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("bp_pop_dat", 128'(rd_data), 128'(ent(1)));
        chk("bp_pop_count", 128'(count), 128'(4));
        do_arm();
        chk("rearm_vld", 128'(rd_valid), 128'(0));
        chk("rearm_state", 128'(state), 128'(1));
        chk("rearm_count", 128'(count), 128'(0));

        // Trigger coincident with stop still records the trigger sample
        trig_pc = 32'h40;
        feed_range(0, 0);
        drive(16);
        stop = 1'b1;
        step();
        stop = 1'b0;
        in_valid = 1'b0;
        chk("ts_trig", 128'(triggered), 128'(1));
        chk("ts_count", 128'(count), 128'(2));

        // Asynchronous reset during POST
        do_arm();
        trig_pc = 32'h28;
        feed_range(0, 12);
        chk("post_state", 128'(state), 128'(2));
        chk("post_count", 128'(count), 128'(13));
        #3;
        rst = 1'b1;
        #1;
        chk("arst_state", 128'(state), 128'(0));
        chk("arst_count", 128'(count), 128'(0));
        chk("arst_vld", 128'(rd_valid), 128'(0));
        chk("arst_data", 128'(rd_data), 128'(0));
        chk("arst_trig", 128'(triggered), 128'(0));
        step();
        step();
        rst = 1'b0;
        step();

        // Trigger match in IDLE is ignored
        trig_pc = 32'h28;
        feed_range(10, 10);
        chk("idle_state", 128'(state), 128'(0));
        chk("idle_trig", 128'(triggered), 128'(0));
        chk("idle_count", 128'(count), 128'(0));

`ifdef TRACE_TIMESTAMP_EN
        do_arm();
        trig_pc = 32'hFFFF_FFFF;
        feed_range(1, 1);
        step();
        feed_range(2, 2);
        step();
        step();
        feed_range(3, 3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        ts0 = rd_ts;
        rd_ready = 1'b1;
        step();
        ts1 = rd_ts;
        step();
        ts2 = rd_ts;
        rd_ready = 1'b0;
        step();
        chk("tstamp_d1", 128'(ts1 - ts0), 128'(2));
        chk("tstamp_d2", 128'(ts2 - ts1), 128'(3));
`else
        ts0 = '0;
        ts1 = '0;
        ts2 = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
